// File: rtl/bus_pkg.sv
// Shared definitions for the two-master system bus arbiter.
package bus_pkg;

    localparam int unsigned BUS_ADDR_W = 32;
    localparam int unsigned BUS_DATA_W = 32;
    localparam int unsigned BUS_LANE_W = 4;

    localparam logic [BUS_DATA_W-1:0] BUS_ERR_DATA = 32'hFFFF_FFFF;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bus_state_e;

endpackage

// File: rtl/bus_watchdog.sv
// Saturating cycle counter; expire marks the last permitted BUSY cycle.
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = en && (count == LAST);

endmodule

// File: rtl/bus_arbiter2.sv
// Round-robin arbiter sharing the system bus between the core (M0) and the DMA/loader (M1),
// with a forced IDLE gap after every transaction and a watchdog for hung slaves.
module bus_arbiter2
    import bus_pkg::*;
#(
    parameter int unsigned            TIMEOUT  = 256,
    parameter logic [BUS_DATA_W-1:0]  ERR_DATA = BUS_ERR_DATA
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BUS_ADDR_W-1:0] m0_addr,
    input  logic [BUS_DATA_W-1:0] m0_wdata,
    input  logic [BUS_LANE_W-1:0] m0_lane,
    input  logic                  m0_wr,
    input  logic                  m0_valid,
    output logic                  m0_ready,
    output logic [BUS_DATA_W-1:0] m0_rdata,
    input  logic [BUS_ADDR_W-1:0] m1_addr,
    input  logic [BUS_DATA_W-1:0] m1_wdata,
    input  logic [BUS_LANE_W-1:0] m1_lane,
    input  logic                  m1_wr,
    input  logic                  m1_valid,
    output logic                  m1_ready,
    output logic [BUS_DATA_W-1:0] m1_rdata,
    output logic [BUS_ADDR_W-1:0] s_addr,
    output logic [BUS_DATA_W-1:0] s_wdata,
    output logic [BUS_LANE_W-1:0] s_lane,
    output logic                  s_wr,
    output logic                  s_valid,
    input  logic [BUS_DATA_W-1:0] s_rdata,
    input  logic                  s_ready,
    output logic                  owner,
    output logic                  busy,
    output logic                  err,
    output logic [BUS_ADDR_W-1:0] err_addr
);

    bus_state_e state;
    logic       owner_valid;
    logic       done_ok;
    logic       done_to;
    logic       finish;
    logic       expire;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == IDLE),
        .en     (state == BUSY),
        .expire (expire)
    );

    // Forward the owner's request; a completing slave beats a simultaneous timeout.
    always_comb begin
        owner_valid = owner ? m1_valid : m0_valid;
        s_addr      = owner ? m1_addr  : m0_addr;
        s_wdata     = owner ? m1_wdata : m0_wdata;
        s_lane      = owner ? m1_lane  : m0_lane;
        s_wr        = owner ? m1_wr    : m0_wr;
        s_valid     = (state == BUSY) && owner_valid;
        done_ok     = s_valid && s_ready;
        done_to     = s_valid && !s_ready && expire;
        finish      = done_ok || done_to;
        m0_ready    = finish && !owner;
        m1_ready    = finish && owner;
        m0_rdata    = (done_to && !owner) ? ERR_DATA : s_rdata;
        m1_rdata    = (done_to && owner)  ? ERR_DATA : s_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b1;
            busy     <= 1'b0;
            err      <= 1'b0;
            err_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        state <= BUSY;
                        busy  <= 1'b1;
                        owner <= (m0_valid && m1_valid) ? ~owner : m1_valid;
                    end
                end
                BUSY: begin
                    if (!owner_valid || finish) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    if (done_to) begin
                        err <= 1'b1;
                        if (!err) begin
                            err_addr <= s_addr;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
